// File: rtl/mfcc_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : mfcc_frame_sched
// Description : Frame scheduler for an MFCC front end. Buffers incoming PCM
//               samples in a 2*FRAME_LEN circular buffer, streams overlapping
//               frames (advance HOP) to the MFCC datapath with a valid/ready
//               handshake, then collects NUM_COEF coefficients per frame and
//               aborts the wait after TIMEOUT cycles.
// Ports       : clk, rst (async, active-low)
//               audio_sample/sample_valid  - PCM input, no backpressure
//               enable                     - permits new frame starts
//               dp_sample/dp_valid/dp_ready - frame samples to datapath
//               mfcc_feature/mfcc_valid    - coefficients from datapath
//               coef_out/coef_valid/coef_idx - captured coefficient
//               frame_idx/frame_done       - frame counter / completion pulse
//               busy, overrun, timeout_err - status (last two sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module mfcc_frame_sched #(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int NUM_COEF  = 13,
  parameter int TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_sample,
  input  logic        sample_valid,
  input  logic        enable,
  output logic [15:0] dp_sample,
  output logic        dp_valid,
  input  logic        dp_ready,
  input  logic [15:0] mfcc_feature,
  input  logic        mfcc_valid,
  output logic [15:0] coef_out,
  output logic        coef_valid,
  output logic [3:0]  coef_idx,
  output logic [15:0] frame_idx,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  // Wait counter only needs to reach TIMEOUT-1.
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [15:0]   sample_mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW:0]   avail_q, avail_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] hs_cnt_q, hs_cnt_d;
  logic [3:0]    coef_cnt_q, coef_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]   dp_sample_q, dp_sample_d;
  logic          dp_valid_q, dp_valid_d;
  logic [15:0]   coef_out_q, coef_out_d;
  logic          coef_valid_q, coef_valid_d;
  logic [3:0]    coef_idx_q, coef_idx_d;
  logic [15:0]   frame_idx_q, frame_idx_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic          w_in_frame;
  logic [AW+1:0] w_occ;
  logic          w_full;
  logic          w_accept;
  logic          w_trigger;
  logic          w_hs;
  logic          w_last_hs;
  logic          w_capture;
  logic          w_last_coef;
  logic          w_expire;
  logic [AW-1:0] w_rd_addr;
  logic [15:0]   w_rd_data;

  // While a frame is being read, its start lies HOP behind head, so the
  // protected span is avail+HOP; otherwise it is just avail. Tracking it via
  // avail removes the full/empty ambiguity of comparing pointers alone.
  assign w_in_frame  = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign w_occ       = {1'b0, avail_q} + (w_in_frame ? (AW+2)'(HOP) : (AW+2)'(0));
  assign w_full      = (w_occ == (AW+2)'(DEPTH));
  assign w_accept    = sample_valid && !w_full;
  assign w_trigger   = (state_q == S_IDLE) && enable && (avail_q >= (AW+1)'(FRAME_LEN));
  assign w_hs        = (state_q == S_STREAM) && dp_valid_q && dp_ready;
  assign w_last_hs   = w_hs && (hs_cnt_q == AW'(FRAME_LEN - 1));
  assign w_capture   = (state_q == S_WAIT) && mfcc_valid;
  assign w_last_coef = w_capture && (coef_cnt_q == 4'(NUM_COEF - 1));
  // Completion on the final cycle takes priority over the timeout.
  assign w_expire    = (state_q == S_WAIT) && !w_last_coef && (wait_cnt_q == TW'(TIMEOUT - 1));

  // LOAD fetches the frame start; in STREAM the next address is prefetched so
  // a handshake every cycle streams without bubbles.
  assign w_rd_addr   = (state_q == S_LOAD) ? rd_ptr_q : rd_ptr_q + AW'(1);
  assign w_rd_data   = sample_mem[w_rd_addr];

  // Sample storage: written in every state, contents are not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      sample_mem[wr_ptr_q] <= audio_sample;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_trigger) state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (w_last_hs) state_d = S_WAIT;
      S_WAIT:   if (w_last_coef || w_expire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(w_accept);
    avail_d      = avail_q + (AW+1)'(w_accept) - (w_trigger ? (AW+1)'(HOP) : (AW+1)'(0));
    head_d       = head_q;
    rd_ptr_d     = rd_ptr_q;
    hs_cnt_d     = hs_cnt_q;
    coef_cnt_d   = coef_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    dp_sample_d  = dp_sample_q;
    dp_valid_d   = dp_valid_q;
    coef_out_d   = coef_out_q;
    coef_valid_d = 1'b0;
    coef_idx_d   = coef_idx_q;
    frame_done_d = 1'b0;
    // Index advances the cycle after the done pulse, so it names the
    // finished frame while frame_done is high.
    frame_idx_d  = frame_idx_q + 16'(frame_done_q);
    overrun_d    = overrun_q | (sample_valid & w_full);
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (w_trigger) begin
          rd_ptr_d = head_q;
          head_d   = head_q + AW'(HOP);
        end
      end
      S_LOAD: begin
        dp_sample_d = w_rd_data;
        dp_valid_d  = 1'b1;
        hs_cnt_d    = '0;
      end
      S_STREAM: begin
        if (w_last_hs) begin
          dp_valid_d = 1'b0;
          wait_cnt_d = '0;
          coef_cnt_d = '0;
        end else if (w_hs) begin
          dp_sample_d = w_rd_data;
          rd_ptr_d    = rd_ptr_q + AW'(1);
          hs_cnt_d    = hs_cnt_q + AW'(1);
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        if (w_capture) begin
          coef_out_d   = mfcc_feature;
          coef_valid_d = 1'b1;
          coef_idx_d   = coef_cnt_q;
          coef_cnt_d   = coef_cnt_q + 4'd1;
        end
        if (w_last_coef) begin
          frame_done_d = 1'b1;
        end else if (w_expire) begin
          frame_done_d = 1'b1;
          timeout_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      head_q       <= '0;
      avail_q      <= '0;
      rd_ptr_q     <= '0;
      hs_cnt_q     <= '0;
      coef_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      dp_sample_q  <= '0;
      dp_valid_q   <= 1'b0;
      coef_out_q   <= '0;
      coef_valid_q <= 1'b0;
      coef_idx_q   <= '0;
      frame_idx_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      head_q       <= head_d;
      avail_q      <= avail_d;
      rd_ptr_q     <= rd_ptr_d;
      hs_cnt_q     <= hs_cnt_d;
      coef_cnt_q   <= coef_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      dp_sample_q  <= dp_sample_d;
      dp_valid_q   <= dp_valid_d;
      coef_out_q   <= coef_out_d;
      coef_valid_q <= coef_valid_d;
      coef_idx_q   <= coef_idx_d;
      frame_idx_q  <= frame_idx_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign dp_sample   = dp_sample_q;
  assign dp_valid    = dp_valid_q;
  assign coef_out    = coef_out_q;
  assign coef_valid  = coef_valid_q;
  assign coef_idx    = coef_idx_q;
  assign frame_idx   = frame_idx_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mfcc_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfcc_frame_sched
// Description : Self-checking bench for mfcc_frame_sched (FRAME_LEN=8, HOP=4,
//               NUM_COEF=3, TIMEOUT=20). Frame k is expected to carry the
//               accepted samples k*HOP .. k*HOP+FRAME_LEN-1 in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfcc_frame_sched;

  localparam int FL  = 8;
  localparam int HP  = 4;
  localparam int NC  = 3;
  localparam int TO  = 20;
  localparam int CAP = 2 * FL;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        enable;
  logic [15:0] dp_sample;
  logic        dp_valid;
  logic        dp_ready;
  logic [15:0] mfcc_feature;
  logic        mfcc_valid;
  logic [15:0] coef_out;
  logic        coef_valid;
  logic [3:0]  coef_idx;
  logic [15:0] frame_idx;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  mfcc_frame_sched #(
    .FRAME_LEN(FL), .HOP(HP), .NUM_COEF(NC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .audio_sample(audio_sample), .sample_valid(sample_valid), .enable(enable),
    .dp_sample(dp_sample), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .mfcc_feature(mfcc_feature), .mfcc_valid(mfcc_valid),
    .coef_out(coef_out), .coef_valid(coef_valid), .coef_idx(coef_idx),
    .frame_idx(frame_idx), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] val [256];   // value of the n-th accepted sample
  int          wr_cnt    = 0; // samples accepted so far
  int          completed = 0; // frames finished (equals index of frame in flight)
  logic        exp_tmo   = 1'b0;

  // Pre-edge snapshot
  logic        pre_valid;
  logic        pre_ready;
  logic [15:0] pre_sample;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    pre_valid  = dp_valid;
    pre_ready  = dp_ready;
    pre_sample = dp_sample;
    @(posedge clk);
    #1;
  endtask

  // Offer a sample only when the model guarantees room; returns 1 if offered.
  task automatic drive_feed(input bit want, output bit offered);
    offered = 1'b0;
    if (want && (wr_cnt - completed * HP) < CAP) begin
      sample_valid = 1'b1;
      audio_sample = val[wr_cnt];
      offered      = 1'b1;
    end else begin
      sample_valid = 1'b0;
      audio_sample = 16'($urandom);
    end
  endtask

  // mode: 0 = dp_ready always 1, 1 = toggling, 2 = random
  task automatic run_frame(input int mode, input bit rfeed, input bit rmisc);
    int  hs = 0;
    int  loads = 0;
    int  cyc = 0;
    int  first_hs = -1;
    int  last_hs = -1;
    bit  seen_valid = 1'b0;
    bit  offered;
    int  base;
    base   = completed * HP;
    enable = 1'b1;
    while (hs < FL && cyc < 400) begin
      case (mode)
        0:       dp_ready = 1'b1;
        1:       dp_ready = (cyc % 2 == 0);
        default: dp_ready = 1'($urandom_range(0, 1));
      endcase
      drive_feed((wr_cnt < base + FL) || (rfeed && $urandom_range(0, 1) == 1), offered);
      mfcc_valid   = rmisc ? 1'($urandom_range(0, 1)) : 1'b0;
      mfcc_feature = 16'($urandom);
      if (rmisc && seen_valid) enable = 1'($urandom_range(0, 1));
      step();
      if (offered) wr_cnt++;
      if (cyc == 0) check("frame_idx_start", frame_idx, 32'(completed));
      if (pre_valid && pre_ready) begin
        check("dp_sample", pre_sample, val[base + hs]);
        if (hs == 0) first_hs = cyc;
        last_hs = cyc;
        hs++;
      end else if (pre_valid && !pre_ready) begin
        check("dp_hold_valid", dp_valid, 1);
        check("dp_hold_sample", dp_sample, val[base + hs]);
      end
      if (!seen_valid && !dp_valid && busy) loads++;
      if (dp_valid) seen_valid = 1'b1;
      if (rmisc) check("mfcc_ignored_stream", coef_valid, 0);
      cyc++;
    end
    check("handshake_count", hs, FL);
    check("dp_valid_drop", dp_valid, 0);
    check("busy_after_stream", busy, 1);
    check("load_one_cycle", loads, 1);
    if (mode == 0) check("no_bubbles", last_hs - first_hs, FL - 1);
    sample_valid = 1'b0;
  endtask

  task automatic coef_phase(input bit tmo, input bit fixed);
    logic [15:0] feats [NC];
    int  sent = 0;
    int  got = 0;
    int  cyc = 0;
    int  waitc = 1;   // WAIT_COEF cycle already observed at the end of streaming
    bit  done = 1'b0;
    bit  cv_at_done = 1'b0;
    for (int i = 0; i < NC; i++) feats[i] = fixed ? 16'(16'h0011 * (i + 1)) : 16'($urandom);
    while (!done && cyc < 100) begin
      sample_valid = 1'b0;
      dp_ready     = 1'($urandom_range(0, 1));
      if (!tmo && sent < NC && (fixed || cyc >= 6 || $urandom_range(0, 1) == 1)) begin
        mfcc_valid   = 1'b1;
        mfcc_feature = feats[sent];
        sent++;
      end else begin
        mfcc_valid   = 1'b0;
        mfcc_feature = 16'($urandom);
      end
      step();
      if (coef_valid) begin
        if (got < NC) begin
          check("coef_out", coef_out, feats[got]);
          check("coef_idx", coef_idx, got);
        end
        got++;
      end
      if (frame_done) begin
        done       = 1'b1;
        cv_at_done = coef_valid;
      end else if (busy) begin
        waitc++;
      end
      cyc++;
    end
    mfcc_valid = 1'b0;
    check("frame_done_seen", done, 1);
    check("frame_idx_at_done", frame_idx, 32'(completed));
    check("idle_after_done", busy, 0);
    if (tmo) begin
      exp_tmo = 1'b1;
      check("timeout_cycles", waitc, TO);
      check("timeout_no_coef", got, 0);
      check("timeout_done_no_cv", cv_at_done, 0);
    end else begin
      check("coef_count", got, NC);
      check("done_with_last_coef", cv_at_done, 1);
    end
    check("timeout_err", timeout_err, exp_tmo);
    completed++;
  endtask

  initial begin
    bit ok;
    bit dropped;
    bit offered;
    for (int n = 0; n < 256; n++) val[n] = (n < 12) ? 16'(n + 1) : 16'($urandom);
    rst          = 1'b0;
    audio_sample = '0;
    sample_valid = 1'b0;
    enable       = 1'b1;
    dp_ready     = 1'b1;
    mfcc_feature = '0;
    mfcc_valid   = 1'b0;
    repeat (3) step();
    check("rst_dp_valid", dp_valid, 0);
    check("rst_dp_sample", dp_sample, 0);
    check("rst_coef", {coef_valid, coef_out, coef_idx}, 0);
    check("rst_frame", {frame_done, frame_idx}, 0);
    check("rst_flags", {busy, overrun, timeout_err}, 0);
    rst = 1'b1;

    // Coefficients offered while idle must be ignored.
    mfcc_valid   = 1'b1;
    mfcc_feature = 16'hBEEF;
    step();
    step();
    check("mfcc_ignored_idle", {coef_valid, frame_done, busy}, 0);
    mfcc_valid = 1'b0;

    // Frame 0: samples 1..8, dp_ready high, coefficients 0x11/0x22/0x33.
    run_frame(0, 1'b0, 1'b0);
    coef_phase(1'b0, 1'b1);

    // Frame 1: samples 9..12 complete it (5..12), toggled dp_ready, timeout.
    run_frame(1, 1'b0, 1'b0);
    coef_phase(1'b1, 1'b0);

    // enable low holds IDLE even with a full frame buffered.
    enable = 1'b0;
    ok     = 1'b1;
    for (int c = 0; c < 16; c++) begin
      drive_feed(wr_cnt < completed * HP + FL, offered);
      step();
      if (offered) wr_cnt++;
      if (busy) ok = 1'b0;
    end
    sample_valid = 1'b0;
    check("enable_blocks_start", ok, 1);

    // Randomised frames with concurrent writes, stalls, stray mfcc_valid and
    // enable dropping mid-frame.
    for (int f = 0; f < 6; f++) begin
      run_frame(2, 1'b1, 1'b1);
      coef_phase(1'b0, 1'b0);
    end
    check("timeout_sticky", timeout_err, 1);
    check("no_overrun_yet", overrun, 0);

    // Overrun: stall the datapath and keep writing.
    enable   = 1'b1;
    dp_ready = 1'b0;
    dropped  = 1'b0;
    for (int c = 0; c < CAP + 4; c++) begin
      sample_valid = 1'b1;
      audio_sample = val[wr_cnt];
      if (wr_cnt - completed * HP < CAP) begin
        step();
        wr_cnt++;
      end else begin
        step();
        dropped = 1'b1;
      end
      check("overrun_flag", overrun, dropped);
    end
    sample_valid = 1'b0;
    check("stall_dp_valid", dp_valid, 1);
    check("stall_dp_sample", dp_sample, val[completed * HP]);
    check("frame_idx_nonzero", frame_idx, 32'(completed));

    // Asynchronous reset in the middle of a streaming frame.
    #2;
    rst = 1'b0;
    #1;
    check("arst_dp", {dp_valid, dp_sample}, 0);
    check("arst_coef", {coef_valid, coef_out, coef_idx}, 0);
    check("arst_frame", {frame_done, frame_idx}, 0);
    check("arst_flags", {busy, overrun, timeout_err}, 0);
    step();
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
